// File: rtl/ysyx_24070017_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_24070017_ifu_pkg;
  localparam int          WORD_LENGTH = 32;
  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  localparam int          INST_BYTES  = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } FETCH_STATE;
endpackage

// File: rtl/ysyx_24070017_ifu_if.sv
// Fetch-side bundle: imem request/response, decode handshake and execute redirect.
interface ysyx_24070017_ifu_if #(parameter int W = ysyx_24070017_ifu_pkg::WORD_LENGTH);
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst;
  logic [W-1:0] inst_pc;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_24070017_Reg.sv
// Generic enable register with synchronous active-high reset to a constant.
module ysyx_24070017_Reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);
  always_ff @(posedge clk) begin
    if (rst)        o_dout <= RESET_VAL;
    else if (i_wen) o_dout <= i_din;
  end
endmodule

// File: rtl/ysyx_24070017_ifu.sv
// Fetch unit: one outstanding imem request, holds each instruction until decode
// takes it, and drops the in-flight response when execute redirects.
module ysyx_24070017_ifu
  import ysyx_24070017_ifu_pkg::*;
#(
  parameter int                     WORD_LENGTH = ysyx_24070017_ifu_pkg::WORD_LENGTH,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = ysyx_24070017_ifu_pkg::RESET_PC
) (
  input logic                clk,
  input logic                rst,
  ysyx_24070017_ifu_if.master bus
);
  FETCH_STATE             r_state, w_state_nxt;
  logic                   r_drop, w_drop_nxt;
  logic [31:0]            r_inst;
  logic                   w_inst_wen;
  logic                   w_pc_wen;
  logic [WORD_LENGTH-1:0] w_pc, w_pc_nxt, w_redir_pc;

  assign w_redir_pc = bus.redirect_pc & ~WORD_LENGTH'(3);

  ysyx_24070017_Reg #(.WIDTH(WORD_LENGTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .i_wen  (w_pc_wen),
    .i_din  (w_pc_nxt),
    .o_dout (w_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_inst_wen  = 1'b0;
    w_pc_wen    = 1'b0;
    w_pc_nxt    = w_redir_pc;
    case (r_state)
      REQ: begin
        w_pc_wen = bus.redirect_valid;
        if (bus.imem_req_ready) begin
          w_state_nxt = WAIT;
          // Accepted with the old address while redirecting: its data is stale.
          w_drop_nxt  = bus.redirect_valid;
        end
      end
      WAIT: begin
        w_pc_wen = bus.redirect_valid;
        if (bus.imem_resp_valid) begin
          w_drop_nxt = 1'b0;
          if (!r_drop && !bus.redirect_valid) begin
            w_inst_wen  = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = REQ;
          end
        end else if (bus.redirect_valid) begin
          w_drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          w_pc_wen    = 1'b1;
          w_state_nxt = REQ;
        end else if (bus.inst_ready) begin
          w_pc_wen    = 1'b1;
          w_pc_nxt    = w_pc + WORD_LENGTH'(INST_BYTES);
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_drop  <= 1'b0;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_inst_wen) r_inst <= bus.imem_resp_data;
    end
  end

  assign bus.imem_req_valid = (r_state == REQ)  && !rst;
  assign bus.imem_req_addr  = w_pc;
  assign bus.inst_valid     = (r_state == HOLD) && !rst;
  assign bus.inst           = r_inst;
  assign bus.inst_pc        = w_pc;
endmodule

// File: tb/tb_ysyx_24070017_ifu.sv
// Directed bench for the fetch unit; the bench plays imem, decode and execute.
module tb_ysyx_24070017_ifu;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ysyx_24070017_ifu_if #(.W(32)) bus ();

  ysyx_24070017_ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request followed by a zero-wait response; ends in HOLD.
  task automatic fetch(input logic [31:0] data);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    tick();
    bus.imem_resp_valid = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    tick();
    tick();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0);

    // Basic fetch
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h8000_0000);
    fetch(32'h0000_0413);
    chk("first_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("first_inst", bus.inst, 32'h0000_0413);
    chk("first_inst_pc", bus.inst_pc, 32'h8000_0000);

    // Stall in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) tick();
    chk("hold_inst", bus.inst, 32'h0000_0413);
    chk("hold_inst_pc", bus.inst_pc, 32'h8000_0000);
    chk("hold_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("seq_req_addr", bus.imem_req_addr, 32'h8000_0004);
    chk("seq_inst_valid", 32'(bus.inst_valid), 32'd0);

    // Redirect in WAIT before the response: the returned word is dropped
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("drop_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("drop_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("drop_req_addr", bus.imem_req_addr, 32'h8000_0100);

    // Redirect coincident with inst_ready wins over pc+4
    fetch(32'h0010_0093);
    chk("redir_hold_inst", bus.inst, 32'h0010_0093);
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    tick();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("redir_hold_addr", bus.imem_req_addr, 32'h8000_0200);

    // imem not ready for 3 cycles, redirect in cycle 2
    bus.imem_req_ready = 1'b0;
    tick();
    chk("stall_addr_c1", bus.imem_req_addr, 32'h8000_0200);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0040;
    tick();
    bus.redirect_valid = 1'b0;
    chk("stall_addr_c2", bus.imem_req_addr, 32'h8000_0040);
    tick();
    chk("stall_addr_c3", bus.imem_req_addr, 32'h8000_0040);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
    fetch(32'h0000_0013);
    chk("stall_inst_pc", bus.inst_pc, 32'h8000_0040);

    // Two redirects in WAIT: the last one is fetched next
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("multi_start_addr", bus.imem_req_addr, 32'h8000_0044);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0300;
    tick();
    bus.redirect_pc    = 32'h8000_0400;
    tick();
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h1234_5678;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("multi_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("multi_req_addr", bus.imem_req_addr, 32'h8000_0400);

    // Wrap at top of address space; low redirect bits are forced to zero
    fetch(32'h0000_0001);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0002);
    chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("wrap_req_addr", bus.imem_req_addr, 32'h0000_0000);

    // Reset while holding an instruction
    fetch(32'h0000_0003);
    chk("prerst_inst_valid", 32'(bus.inst_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_gate_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("postrst_req_addr", bus.imem_req_addr, 32'h8000_0000);
    chk("postrst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("postrst_inst", bus.inst, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
